runway_traffic_controller: RTL

- Consumes the weather-alert outputs of the emergency/weather control unit (severe_weather, emergency_landing_alert, 2-bit weather state).
- Arbitrates a single runway between queued landing and takeoff requests.
- Holds two FIFOs, one for landings and one for takeoffs, and grants the runway to one aircraft at a time.
- Blocks takeoffs under adverse weather and tracks how long the runway is occupied.

---
 rtl/runway_traffic_controller.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/runway_traffic_controller.sv
`default_nettype none
// ============================================================================
//  Module      : runway_traffic_controller
//  Description : Single-runway arbiter. Landing and takeoff requests are
//                queued in two circular FIFOs. Landings are granted first
//                and are never blocked. Takeoffs are held back in adverse
//                weather. Runway occupancy is timed so that a stuck runway
//                can be flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module runway_traffic_controller #(
  parameter int DEPTH   = 4,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 100
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         severe_weather,
  input  logic                         emergency_landing_alert,
  input  logic [1:0]                   weather_state,
  input  logic                         land_req,
  input  logic [ID_W-1:0]              land_id,
  input  logic                         takeoff_req,
  input  logic [ID_W-1:0]              takeoff_id,
  input  logic                         runway_release,
  output logic                         land_grant,
  output logic                         takeoff_grant,
  output logic [ID_W-1:0]              grant_id,
  output logic [1:0]                   runway_state,
  output logic [$clog2(DEPTH+1)-1:0]   land_count,
  output logic [$clog2(DEPTH+1)-1:0]   takeoff_count,
  output logic                         land_full,
  output logic                         takeoff_full,
  output logic                         req_dropped,
  output logic                         runway_timeout
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [PW-1:0] C_LAST_PTR = PW'(DEPTH - 1);
  localparam logic [OW-1:0] C_TIMEOUT  = OW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_LANDING = 2'b01,
    S_TAKEOFF = 2'b10
  } state_t;

  // Runway FSM and grant registers
  state_t            state_q, state_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              timeout_q, timeout_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              land_grant_q, land_grant_d;
  logic              to_grant_q, to_grant_d;
  logic              dropped_q, dropped_d;

  // Queue storage and bookkeeping
  logic [ID_W-1:0]   land_mem_q [DEPTH];
  logic [ID_W-1:0]   to_mem_q   [DEPTH];
  logic [PW-1:0]     land_rd_q, land_rd_d, land_wr_q, land_wr_d;
  logic [PW-1:0]     to_rd_q, to_rd_d, to_wr_q, to_wr_d;
  logic [CW-1:0]     land_cnt_q, land_cnt_d, to_cnt_q, to_cnt_d;

  logic              takeoff_allowed;
  logic              land_push, land_drop, land_pop;
  logic              to_push, to_drop, to_pop;

  // Circular pointer advance; written generically so DEPTH wrap is explicit.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Queue push/pop/drop decisions, taken from occupancy at the start of the cycle.
  always_comb begin
    takeoff_allowed = !severe_weather && !emergency_landing_alert && !weather_state[1];
    land_push = land_req && (land_cnt_q != C_DEPTH);
    land_drop = land_req && (land_cnt_q == C_DEPTH);
    to_push   = takeoff_req && (to_cnt_q != C_DEPTH);
    to_drop   = takeoff_req && (to_cnt_q == C_DEPTH);
    land_pop  = (state_q == S_IDLE) && (land_cnt_q != '0);
    to_pop    = (state_q == S_IDLE) && (land_cnt_q == '0) && (to_cnt_q != '0) && takeoff_allowed;
    dropped_d = land_drop || to_drop;
  end

  // Queue pointer and occupancy next-state.
  always_comb begin
    land_wr_d  = land_push ? ptr_inc(land_wr_q) : land_wr_q;
    land_rd_d  = land_pop  ? ptr_inc(land_rd_q) : land_rd_q;
    to_wr_d    = to_push   ? ptr_inc(to_wr_q)   : to_wr_q;
    to_rd_d    = to_pop    ? ptr_inc(to_rd_q)   : to_rd_q;
    land_cnt_d = land_cnt_q;
    to_cnt_d   = to_cnt_q;
    case ({land_push, land_pop})
      2'b10:   land_cnt_d = land_cnt_q + 1'b1;
      2'b01:   land_cnt_d = land_cnt_q - 1'b1;
      default: land_cnt_d = land_cnt_q;
    endcase
    case ({to_push, to_pop})
      2'b10:   to_cnt_d = to_cnt_q + 1'b1;
      2'b01:   to_cnt_d = to_cnt_q - 1'b1;
      default: to_cnt_d = to_cnt_q;
    endcase
  end

  // Runway FSM: grant decisions in IDLE, occupancy timing while busy.
  always_comb begin
    state_d      = state_q;
    occ_d        = occ_q;
    timeout_d    = timeout_q;
    grant_id_d   = grant_id_q;
    land_grant_d = 1'b0;
    to_grant_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (land_pop) begin
          grant_id_d   = land_mem_q[land_rd_q];
          land_grant_d = 1'b1;
          state_d      = S_LANDING;
        end else if (to_pop) begin
          grant_id_d   = to_mem_q[to_rd_q];
          to_grant_d   = 1'b1;
          state_d      = S_TAKEOFF;
        end
      end
      S_LANDING, S_TAKEOFF: begin
        if (runway_release) begin
          state_d   = S_IDLE;
          occ_d     = '0;
          timeout_d = 1'b0;
        end else begin
          if (occ_q != C_TIMEOUT) begin
            occ_d = occ_q + 1'b1;
          end
          // Sticky: the runway is never freed automatically, only flagged.
          if (occ_d == C_TIMEOUT) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and control registers; reset discards any in-flight grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      occ_q        <= '0;
      timeout_q    <= 1'b0;
      grant_id_q   <= '0;
      land_grant_q <= 1'b0;
      to_grant_q   <= 1'b0;
      dropped_q    <= 1'b0;
      land_rd_q    <= '0;
      land_wr_q    <= '0;
      to_rd_q      <= '0;
      to_wr_q      <= '0;
      land_cnt_q   <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      timeout_q    <= timeout_d;
      grant_id_q   <= grant_id_d;
      land_grant_q <= land_grant_d;
      to_grant_q   <= to_grant_d;
      dropped_q    <= dropped_d;
      land_rd_q    <= land_rd_d;
      land_wr_q    <= land_wr_d;
      to_rd_q      <= to_rd_d;
      to_wr_q      <= to_wr_d;
      land_cnt_q   <= land_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  // Queue storage; contents are meaningless while empty, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (land_push) begin
      land_mem_q[land_wr_q] <= land_id;
    end
    if (to_push) begin
      to_mem_q[to_wr_q] <= takeoff_id;
    end
  end

  assign land_grant     = land_grant_q;
  assign takeoff_grant  = to_grant_q;
  assign grant_id       = grant_id_q;
  assign runway_state   = state_q;
  assign land_count     = land_cnt_q;
  assign takeoff_count  = to_cnt_q;
  assign land_full      = (land_cnt_q == C_DEPTH);
  assign takeoff_full   = (to_cnt_q == C_DEPTH);
  assign req_dropped    = dropped_q;
  assign runway_timeout = timeout_q;

endmodule
`default_nettype wire
